// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Imported by the fetch interface and the fetch_ctrl top.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    DELIVER
  } fetch_state_t;

  localparam int INSTR_BYTES = 4;

  // Wide enough for any address width we build; callers slice the low bits.
  localparam logic [63:0] ALIGN_MASK = ~64'(INSTR_BYTES - 1);

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory port: valid/ready request channel plus valid-only response.
// master = fetch side, slave = memory side.
interface fetch_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one imem request at a time, hands
// one instruction to decode with stall back-pressure, and applies redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  input  logic                     stall,
  fetch_ctrl_if.master             imem,
  output logic                     instr_valid,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  fetch_state_t             state;
  logic                     drop;
  logic [ADDRESS_WIDTH-1:0] tgt;
  logic [ADDRESS_WIDTH-1:0] pc_inc;

  assign tgt    = redirect_target & ALIGN_MASK[ADDRESS_WIDTH-1:0];
  assign pc_inc = pc + ADDRESS_WIDTH'(INSTR_BYTES);

  // Request is decoded from state so the address can never move under a pending request
  // except through pc itself.
  assign imem.req_valid = (state == FETCH);
  assign imem.req_addr  = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redirect_valid) pc <= tgt;
        end
        FETCH: begin
          if (redirect_valid) pc <= tgt;
          if (imem.req_ready) begin
            state <= WAIT;
            // A redirect on the accept edge makes the in-flight word stale.
            drop  <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem.rsp_valid) begin
            drop <= 1'b0;
            if (redirect_valid) pc <= tgt;
            if (drop || redirect_valid) begin
              state <= FETCH;
            end else begin
              instr       <= imem.rsp_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= DELIVER;
            end
          end else if (redirect_valid) begin
            pc   <= tgt;
            drop <= 1'b1;
          end
        end
        DELIVER: begin
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc          <= tgt;
            state       <= FETCH;
          end else if (!stall) begin
            instr_valid <= 1'b0;
            pc          <= pc_inc;
            state       <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    imem.req_valid && !imem.req_ready && !redirect_valid
      |=> imem.req_valid && $stable(imem.req_addr));

  a_req_vs_deliver: assert property (@(posedge clk) disable iff (!rst)
    !(imem.req_valid && instr_valid));

endmodule
